// File: rtl/multiplexor_barrido.sv
// multiplexor_barrido: registered N:1 channel selector with an automatic scan
// mode. In scan mode a contiguous (optionally wrapping) channel range is
// streamed one channel per beat over VALID/READY, followed by a DONE pulse.
module multiplexor_barrido #(
    parameter int Width = 8,
    parameter int NumCh = 8,
    parameter int SelW  = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   MODO,
    input  logic [SelW-1:0]        SEL,
    input  logic                   START,
    input  logic [SelW-1:0]        FIRST,
    input  logic [SelW-1:0]        LAST,
    input  logic [NumCh*Width-1:0] In,
    input  logic                   READY,
    output logic [Width-1:0]       Out,
    output logic                   VALID,
    output logic [SelW-1:0]        CH,
    output logic                   BUSY,
    output logic                   DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [SelW-1:0]  r_ptr,   w_ptr_next;
    logic [SelW-1:0]  r_last,  w_last_next;
    logic [Width-1:0] r_out,   w_out_next;
    logic             r_valid, w_valid_next;
    logic [SelW-1:0]  r_ch,    w_ch_next;
    logic             r_done,  w_done_next;

    logic [Width-1:0] w_chan [NumCh];
    logic [Width-1:0] w_sel_data;
    logic [Width-1:0] w_first_data;
    logic [Width-1:0] w_ptr_data;
    logic             w_range_ok;
    logic             w_xfer;

    // Unpack the flat input bus into one entry per channel.
    for (genvar gi = 0; gi < NumCh; gi++) begin : g_chan
        assign w_chan[gi] = In[gi*Width +: Width];
    end

    // Successor channel in scan order; the top channel wraps to zero.
    function automatic logic [SelW-1:0] next_ch(input logic [SelW-1:0] x);
        if (int'(x) == NumCh - 1)
            return '0;
        return x + SelW'(1);
    endfunction

    // Manual selects beyond the channel count read as zero.
    assign w_sel_data   = (int'(SEL) < NumCh) ? w_chan[SEL] : '0;
    assign w_first_data = (int'(FIRST) < NumCh) ? w_chan[FIRST] : '0;
    assign w_ptr_data   = w_chan[r_ptr];
    assign w_range_ok   = (int'(FIRST) < NumCh) && (int'(LAST) < NumCh);
    assign w_xfer       = r_valid && READY;

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_last  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_last  <= w_last_next;
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
            r_ch    <= w_ch_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_last_next  = r_last;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        w_ch_next    = r_ch;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!MODO) begin
                    w_out_next   = w_sel_data;
                    w_ch_next    = SEL;
                    w_valid_next = 1'b1;
                end else begin
                    w_valid_next = 1'b0;
                    if (START && w_range_ok) begin
                        w_out_next   = w_first_data;
                        w_ch_next    = FIRST;
                        w_valid_next = 1'b1;
                        w_last_next  = LAST;
                        if (FIRST == LAST) begin
                            w_state_next = S_DRAIN;
                        end else begin
                            w_ptr_next   = next_ch(FIRST);
                            w_state_next = S_SCAN;
                        end
                    end
                end
            end
            S_SCAN: begin
                if (w_xfer) begin
                    w_out_next = w_ptr_data;
                    w_ch_next  = r_ptr;
                    if (r_ptr == r_last)
                        w_state_next = S_DRAIN;
                    else
                        w_ptr_next = next_ch(r_ptr);
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign Out   = r_out;
    assign VALID = r_valid;
    assign CH    = r_ch;
    assign BUSY  = (r_state != S_IDLE);
    assign DONE  = r_done;

endmodule

// File: tb/tb_multiplexor_barrido.sv
// Testbench for multiplexor_barrido: directed scenarios plus randomized
// manual/scan traffic checked against an abstract beat-sequence model.
module tb_multiplexor_barrido;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        MODO = 1'b1;
    logic [2:0]  SEL = '0;
    logic        START = 1'b0;
    logic [2:0]  FIRST = '0;
    logic [2:0]  LAST = '0;
    logic [63:0] In = '0;
    logic        READY = 1'b0;
    logic [7:0]  Out;
    logic        VALID;
    logic [2:0]  CH;
    logic        BUSY;
    logic        DONE;

    // Second instance with six channels, used for out-of-range requests.
    logic        b_MODO = 1'b1;
    logic [2:0]  b_SEL = '0;
    logic        b_START = 1'b0;
    logic [2:0]  b_FIRST = '0;
    logic [2:0]  b_LAST = '0;
    logic [47:0] b_In = '0;
    logic        b_READY = 1'b0;
    logic [7:0]  b_Out;
    logic        b_VALID;
    logic [2:0]  b_CH;
    logic        b_BUSY;
    logic        b_DONE;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_out = '0;
    logic [2:0]  exp_ch = '0;
    logic [63:0] base_in;

    multiplexor_barrido #(.Width(8), .NumCh(8), .SelW(3)) dut (
        .CLK(clk), .RST(RST), .MODO(MODO), .SEL(SEL), .START(START),
        .FIRST(FIRST), .LAST(LAST), .In(In), .READY(READY), .Out(Out),
        .VALID(VALID), .CH(CH), .BUSY(BUSY), .DONE(DONE)
    );

    multiplexor_barrido #(.Width(8), .NumCh(6), .SelW(3)) dut6 (
        .CLK(clk), .RST(RST), .MODO(b_MODO), .SEL(b_SEL), .START(b_START),
        .FIRST(b_FIRST), .LAST(b_LAST), .In(b_In), .READY(b_READY), .Out(b_Out),
        .VALID(b_VALID), .CH(b_CH), .BUSY(b_BUSY), .DONE(b_DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chan(input logic [63:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    task automatic check_outputs(input string tag, input bit valid, input bit busy, input bit done);
        check({tag, "_out"}, 32'(Out), 32'(exp_out));
        check({tag, "_ch"}, 32'(CH), 32'(exp_ch));
        check({tag, "_valid"}, 32'(VALID), 32'(valid));
        check({tag, "_busy"}, 32'(BUSY), 32'(busy));
        check({tag, "_done"}, 32'(DONE), 32'(done));
    endtask

    // Manual mode: registered copy of the selected channel, READY irrelevant.
    task automatic do_manual(input int sel, input bit fuzz);
        logic [63:0] snap;
        MODO  = 1'b0;
        SEL   = 3'(sel);
        READY = 1'($urandom_range(0, 1));
        if (fuzz) In = {$urandom, $urandom};
        snap = In;
        tick();
        exp_out = chan(snap, sel);
        exp_ch  = 3'(sel);
        check_outputs("manual", 1'b1, 1'b0, 1'b0);
        $display("manual sel=%0d out=%0h", sel, Out);
    endtask

    // Scan mode idle without START: VALID drops, Out/CH hold.
    task automatic do_idle();
        MODO  = 1'b1;
        START = 1'b0;
        tick();
        check_outputs("idle", 1'b0, 1'b0, 1'b0);
        $display("idle out=%0h ch=%0d", Out, CH);
    endtask

    // One scan request. Model: beat i carries channel (first+i) mod 8, taken
    // from In as it was on the edge that loaded that beat. rmode: 0 READY
    // always high, 1 alternating starting low, 2 random.
    task automatic do_scan(input int first, input int last, input int rmode, input bit fuzz);
        int          n;
        int          idx;
        int          cyc;
        bit          rdy;
        logic [63:0] snap;
        n = ((last - first + 8) % 8) + 1;
        MODO  = 1'b1;
        START = 1'b1;
        FIRST = 3'(first);
        LAST  = 3'(last);
        snap  = In;
        tick();
        START   = 1'b0;
        exp_ch  = 3'(first);
        exp_out = chan(snap, first);
        check_outputs("scan_beat0", 1'b1, 1'b1, 1'b0);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 64) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            READY = rdy;
            if (fuzz) begin
                In    = {$urandom, $urandom};
                START = 1'($urandom_range(0, 1));
                MODO  = 1'($urandom_range(0, 1));
                FIRST = 3'($urandom);
                LAST  = 3'($urandom);
                SEL   = 3'($urandom);
            end
            snap = In;
            tick();
            cyc++;
            if (rdy) idx++;
            if (idx == n) begin
                check_outputs("scan_done", 1'b0, 1'b0, 1'b1);
            end else begin
                if (rdy) begin
                    exp_ch  = 3'((first + idx) % 8);
                    exp_out = chan(snap, int'(exp_ch));
                end
                check_outputs("scan_beat", 1'b1, 1'b1, 1'b0);
            end
        end
        if (idx < n) check("scan_timeout", 32'(idx), 32'(n));
        START = 1'b0;
        MODO  = 1'b1;
        $display("scan first=%0d last=%0d beats=%0d cycles=%0d", first, last, n, cyc);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) base_in[k*8 +: 8] = 8'h10 + 8'(k);
        In = base_in;
        for (int k = 0; k < 6; k++) b_In[k*8 +: 8] = 8'h10 + 8'(k);

        // Power-on reset.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check_outputs("reset", 1'b0, 1'b0, 1'b0);
        $display("reset out=%0h valid=%0b", Out, VALID);

        // Manual mode, fixed inputs.
        do_manual(5, 1'b0);
        do_manual(2, 1'b0);

        // 2..5 with READY high, then 6..1 wrapping with alternating READY.
        do_scan(2, 5, 0, 1'b0);
        do_idle();
        do_scan(6, 1, 1, 1'b0);
        do_idle();
        // Single beat, then a back-to-back scan fuzzing START while busy.
        do_scan(3, 3, 0, 1'b0);
        do_scan(1, 4, 0, 1'b1);
        In = base_in;
        do_manual(7, 1'b0);

        // Reset in the middle of a 2..5 scan aborts without DONE.
        MODO  = 1'b1;
        START = 1'b1;
        FIRST = 3'd2;
        LAST  = 3'd5;
        READY = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("abort_beat1_out", 32'(Out), 32'h13);
        RST = 1'b1;
        tick();
        exp_out = '0;
        exp_ch  = '0;
        check_outputs("abort_rst1", 1'b0, 1'b0, 1'b0);
        tick();
        check_outputs("abort_rst2", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        do_scan(0, 1, 0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       do_manual(int'($urandom_range(0, 7)), 1'b1);
                1:       do_idle();
                default: do_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                 int'($urandom_range(0, 2)), 1'b1);
            endcase
        end

        // Six-channel instance: out-of-range manual select reads zero.
        b_MODO = 1'b0;
        b_SEL  = 3'd7;
        tick();
        check("ch6_sel7_out", 32'(b_Out), 32'h0);
        check("ch6_sel7_valid", 32'(b_VALID), 32'h1);
        check("ch6_sel7_ch", 32'(b_CH), 32'h7);
        $display("ch6 manual sel=7 out=%0h", b_Out);
        // Out-of-range FIRST or LAST: request ignored.
        b_MODO  = 1'b1;
        b_START = 1'b1;
        b_FIRST = 3'd7;
        b_LAST  = 3'd2;
        tick();
        check("ch6_first7_busy", 32'(b_BUSY), 32'h0);
        check("ch6_first7_valid", 32'(b_VALID), 32'h0);
        b_FIRST = 3'd1;
        b_LAST  = 3'd6;
        tick();
        check("ch6_last6_busy", 32'(b_BUSY), 32'h0);
        check("ch6_last6_valid", 32'(b_VALID), 32'h0);
        $display("ch6 out-of-range start busy=%0b", b_BUSY);
        // Wrapping scan 4..1 on six channels: 4,5,0,1.
        b_FIRST = 3'd4;
        b_LAST  = 3'd1;
        b_READY = 1'b1;
        tick();
        b_START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ch6_wrap_ch", 32'(b_CH), 32'((4 + i) % 6));
            check("ch6_wrap_out", 32'(b_Out), 32'(8'h10 + 8'((4 + i) % 6)));
            check("ch6_wrap_busy", 32'(b_BUSY), 32'h1);
            $display("ch6 wrap beat %0d ch=%0d out=%0h", i, b_CH, b_Out);
            tick();
        end
        check("ch6_wrap_done", 32'(b_DONE), 32'h1);
        check("ch6_wrap_valid", 32'(b_VALID), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
